// File: rtl/uart_rx_core_if.sv
// Handshake bundle between the UART receiver and its word consumer; par_err exists only
// when UART_RX_PARITY_EN is defined.
interface uart_rx_core_if #(
    parameter int DATA_BITS = 8
);
    logic                 RX;
    logic                 clr_rdy;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rdy;
    logic                 frm_err;
    logic                 ovr_err;
`ifdef UART_RX_PARITY_EN
    logic                 par_err;

    modport master (output RX, clr_rdy, input rx_data, rdy, frm_err, ovr_err, par_err);
    modport slave  (input RX, clr_rdy, output rx_data, rdy, frm_err, ovr_err, par_err);
`else
    modport master (output RX, clr_rdy, input rx_data, rdy, frm_err, ovr_err);
    modport slave  (input RX, clr_rdy, output rx_data, rdy, frm_err, ovr_err);
`endif
endinterface

// File: rtl/uart_rx_core.sv
// UART receiver: param baud/width, false-start reject, framing/overrun, parity via UART_RX_PARITY_EN.
// Latency: word lands 2 + CLK_DIV/2 + (DATA_BITS+1+P)*CLK_DIV clk after the start edge is first sampled.
// Backpressure: none on the line; an unacknowledged word is overwritten and flagged on ovr_err.
module uart_rx_core #(
    parameter int CLK_DIV   = 2604,
    parameter int DATA_BITS = 8
`ifdef UART_RX_PARITY_EN
    ,
    parameter bit PARITY_ODD = 1'b0
`endif
) (
    input  logic          clk,
    input  logic          rst,
    uart_rx_core_if.slave bus
);
    localparam int CW = $clog2(CLK_DIV);
    localparam int BW = $clog2(DATA_BITS + 1);

    localparam logic [CW-1:0] RELOAD   = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] HALF     = CW'(CLK_DIV / 2 - 1);
    localparam logic [CW-1:0] ONE_C    = CW'(1);
    localparam logic [BW-1:0] ONE_B    = BW'(1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] START   = 3'd1;
    localparam logic [2:0] DATA    = 3'd2;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] PARITY  = 3'd3;
`endif
    localparam logic [2:0] STOP    = 3'd4;
    localparam logic [2:0] WAIT_HI = 3'd5;

    logic                 rx_meta;
    logic                 rx_s;
    logic [2:0]           state;
    logic [CW-1:0]        baud_cnt;
    logic [BW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 strobe;
    logic                 active;
    logic                 done;

    logic [DATA_BITS-1:0] rx_data_q;
    logic                 rdy_q;
    logic                 frm_err_q;
    logic                 ovr_err_q;

    assign strobe = (baud_cnt == '0);
    assign active = (state != IDLE) && (state != WAIT_HI);
    assign done   = (state == STOP) && strobe;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= bus.RX;
            rx_s    <= rx_meta;
        end
    end

`ifdef UART_RX_PARITY_EN
    logic par_bit;
    logic par_bad;
    logic par_err_q;

    assign par_bad     = ((^shift_reg) ^ par_bit) != PARITY_ODD;
    assign bus.par_err = par_err_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
`ifdef UART_RX_PARITY_EN
            par_bit   <= 1'b0;
`endif
        end else begin
            // Half-bit preload on the start edge puts every later strobe at mid-bit.
            if (state == IDLE) begin
                if (!rx_s) baud_cnt <= HALF;
            end else if (active) begin
                baud_cnt <= strobe ? RELOAD : baud_cnt - ONE_C;
            end

            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state   <= START;
                        bit_cnt <= '0;
                    end
                end
                START: begin
                    if (strobe) state <= rx_s ? IDLE : DATA;
                end
                DATA: begin
                    if (strobe) begin
                        shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]};
                        bit_cnt   <= bit_cnt + ONE_B;
                        if (bit_cnt == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (strobe) begin
                        par_bit <= rx_s;
                        state   <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (strobe) state <= rx_s ? IDLE : WAIT_HI;
                end
                WAIT_HI: begin
                    if (rx_s) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A completion coinciding with clr_rdy reports only the new frame's status.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_data_q <= '0;
            rdy_q     <= 1'b0;
            frm_err_q <= 1'b0;
            ovr_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_err_q <= 1'b0;
`endif
        end else if (done) begin
            rx_data_q <= shift_reg;
            rdy_q     <= 1'b1;
            frm_err_q <= (frm_err_q & ~bus.clr_rdy) | ~rx_s;
            ovr_err_q <= ~bus.clr_rdy & (ovr_err_q | rdy_q);
`ifdef UART_RX_PARITY_EN
            par_err_q <= (par_err_q & ~bus.clr_rdy) | par_bad;
`endif
        end else if (bus.clr_rdy) begin
            rdy_q     <= 1'b0;
            frm_err_q <= 1'b0;
            ovr_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_err_q <= 1'b0;
`endif
        end
    end

    assign bus.rx_data = rx_data_q;
    assign bus.rdy     = rdy_q;
    assign bus.frm_err = frm_err_q;
    assign bus.ovr_err = ovr_err_q;
endmodule

// File: tb/tb_uart_rx_core.sv
// Bench for uart_rx_core: frames are bit-banged at CLK_DIV=16 and results compared with a
// frame-level model of the receiver's outputs (rdy, data, sticky flags).
module tb_uart_rx_core;
    localparam int C = 16;
`ifdef UART_RX_PARITY_EN
    localparam int DB = 7;
    localparam int P  = 1;
`else
    localparam int DB = 8;
    localparam int P  = 0;
`endif
    localparam bit ODD = 1'b0;
    localparam int LAT = 2 + C / 2 + (DB + 1 + P) * C;
    localparam int NB  = DB + 2 + P;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    uart_rx_core_if #(.DATA_BITS(DB)) bus();

    uart_rx_core #(
        .CLK_DIV(C),
        .DATA_BITS(DB)
`ifdef UART_RX_PARITY_EN
        ,
        .PARITY_ODD(ODD)
`endif
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // frame-level model of the consumer-visible state
    logic          m_rdy, m_frm, m_ovr, m_par;
    logic [DB-1:0] m_data;

    // driver results
    int            rise_edge;
    logic          snap_rdy, snap_frm, snap_ovr, snap_par;
    logic [DB-1:0] snap_data;

    task automatic model_reset();
        m_rdy = 0; m_frm = 0; m_ovr = 0; m_par = 0; m_data = '0;
    endtask

    task automatic model_frame(input logic [DB-1:0] data, input bit stop, input bit pbad, input bit clr_same);
        if (clr_same) begin
            m_frm = !stop; m_par = pbad; m_ovr = 0;
        end else begin
            m_frm = m_frm | !stop; m_par = m_par | pbad; m_ovr = m_ovr | m_rdy;
        end
        m_rdy  = 1;
        m_data = data;
    endtask

    task automatic pulse_clr();
        @(negedge clk); bus.clr_rdy = 1'b1;
        @(negedge clk); bus.clr_rdy = 1'b0;
        @(negedge clk);
        m_rdy = 0; m_frm = 0; m_ovr = 0; m_par = 0;
    endtask

    // Drives one frame; edge offset e=0 is the first posedge that sees the start bit.
    task automatic send_frame(input logic [DB-1:0] data, input bit stop, input bit pbad,
                              input int clr_off, input int rst_off, input bit release_line);
        logic [15:0] bits;
        logic        prev;
        int          e;
        bits = '1;
        bits[0] = 1'b0;
        for (int i = 0; i < DB; i++) bits[1+i] = data[i];
        if (P == 1) bits[DB+1] = (^data) ^ ODD ^ pbad;
        bits[NB-1] = stop;
        e = 0;
        rise_edge = -1;
        prev = bus.rdy;
        for (int b = 0; b < NB; b++) begin
            @(negedge clk);
            bus.RX = bits[b];
            for (int k = 0; k < C; k++) begin
                @(posedge clk);
                #1;
                if (bus.rdy && !prev && rise_edge < 0) rise_edge = e;
                prev = bus.rdy;
                if (e == clr_off - 1) bus.clr_rdy = 1'b1;
                else if (e == clr_off) bus.clr_rdy = 1'b0;
                if (e == rst_off) begin
                    rst = 1'b1;
                    #1;
                    snap_rdy = bus.rdy; snap_frm = bus.frm_err; snap_ovr = bus.ovr_err;
                    snap_data = bus.rx_data;
`ifdef UART_RX_PARITY_EN
                    snap_par = bus.par_err;
`else
                    snap_par = 1'b0;
`endif
                end
                if (e == rst_off + 2) rst = 1'b0;
                e++;
            end
        end
        if (release_line) begin
            @(negedge clk); bus.RX = 1'b1;
            repeat (4) @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; bus.RX = 1'b1; bus.clr_rdy = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (bus.rdy !== 1'b0) $display("FAIL reset_rdy got=%b exp=0", bus.rdy); else n_pass++;
        n_checks++; if (bus.rx_data !== '0) $display("FAIL reset_data got=%h exp=0", bus.rx_data); else n_pass++;
        n_checks++; if (bus.frm_err !== 1'b0) $display("FAIL reset_frm got=%b exp=0", bus.frm_err); else n_pass++;
        n_checks++; if (bus.ovr_err !== 1'b0) $display("FAIL reset_ovr got=%b exp=0", bus.ovr_err); else n_pass++;
`ifdef UART_RX_PARITY_EN
        n_checks++; if (bus.par_err !== 1'b0) $display("FAIL reset_par got=%b exp=0", bus.par_err); else n_pass++;
`endif
        rst = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
    endtask

    task automatic test_basic();
        logic [DB-1:0] d;
        d = DB'(8'hA5);
        send_frame(d, 1'b1, 1'b0, -10, -10, 1'b1);
        model_frame(d, 1'b1, 1'b0, 1'b0);
        n_checks++; if (rise_edge != LAT) $display("FAIL basic_latency got=%0d exp=%0d", rise_edge, LAT); else n_pass++;
        n_checks++; if (bus.rx_data !== m_data) $display("FAIL basic_data got=%h exp=%h", bus.rx_data, m_data); else n_pass++;
        n_checks++; if (bus.frm_err !== 1'b0) $display("FAIL basic_frm got=%b exp=0", bus.frm_err); else n_pass++;
        n_checks++; if (bus.ovr_err !== 1'b0) $display("FAIL basic_ovr got=%b exp=0", bus.ovr_err); else n_pass++;
        pulse_clr();
        n_checks++; if (bus.rdy !== 1'b0) $display("FAIL basic_clr_rdy got=%b exp=0", bus.rdy); else n_pass++;
    endtask

    task automatic test_glitch();
        logic [DB-1:0] d;
        @(negedge clk); bus.RX = 1'b0;
        repeat (4) @(negedge clk);
        bus.RX = 1'b1;
        repeat (2 * C) @(negedge clk);
        n_checks++; if (bus.rdy !== 1'b0) $display("FAIL glitch_no_rdy got=%b exp=0", bus.rdy); else n_pass++;
        d = DB'(8'h3C);
        send_frame(d, 1'b1, 1'b0, -10, -10, 1'b1);
        model_frame(d, 1'b1, 1'b0, 1'b0);
        n_checks++; if (rise_edge != LAT) $display("FAIL glitch_next_latency got=%0d exp=%0d", rise_edge, LAT); else n_pass++;
        n_checks++; if (bus.rx_data !== m_data) $display("FAIL glitch_next_data got=%h exp=%h", bus.rx_data, m_data); else n_pass++;
        pulse_clr();
    endtask

    task automatic test_break();
        logic [DB-1:0] d;
        int            highs;
        d = DB'(8'h55);
        send_frame(d, 1'b0, 1'b0, -10, -10, 1'b0);
        model_frame(d, 1'b0, 1'b0, 1'b0);
        n_checks++; if (bus.rdy !== 1'b1) $display("FAIL break_rdy got=%b exp=1", bus.rdy); else n_pass++;
        n_checks++; if (bus.frm_err !== 1'b1) $display("FAIL break_frm got=%b exp=1", bus.frm_err); else n_pass++;
        n_checks++; if (bus.rx_data !== m_data) $display("FAIL break_data got=%h exp=%h", bus.rx_data, m_data); else n_pass++;
        pulse_clr();
        highs = 0;
        for (int i = 0; i < 40 * C; i++) begin
            @(negedge clk);
            if (bus.rdy) highs++;
        end
        bus.RX = 1'b1;
        for (int i = 0; i < 2 * C; i++) begin
            @(negedge clk);
            if (bus.rdy) highs++;
        end
        n_checks++; if (highs != 0) $display("FAIL break_second_frame got=%0d rdy cycles exp=0", highs); else n_pass++;
    endtask

    task automatic test_overrun();
        send_frame(DB'(8'h11), 1'b1, 1'b0, -10, -10, 1'b1);
        model_frame(DB'(8'h11), 1'b1, 1'b0, 1'b0);
        send_frame(DB'(8'h22), 1'b1, 1'b0, -10, -10, 1'b1);
        model_frame(DB'(8'h22), 1'b1, 1'b0, 1'b0);
        n_checks++; if (bus.rx_data !== m_data) $display("FAIL ovr_data got=%h exp=%h", bus.rx_data, m_data); else n_pass++;
        n_checks++; if (bus.ovr_err !== 1'b1) $display("FAIL ovr_flag got=%b exp=1", bus.ovr_err); else n_pass++;
        send_frame(DB'(8'h33), 1'b1, 1'b0, LAT, -10, 1'b1);
        model_frame(DB'(8'h33), 1'b1, 1'b0, 1'b1);
        n_checks++; if (bus.rdy !== 1'b1) $display("FAIL ovr_clr_same_rdy got=%b exp=1", bus.rdy); else n_pass++;
        n_checks++; if (bus.ovr_err !== 1'b0) $display("FAIL ovr_clr_same_ovr got=%b exp=0", bus.ovr_err); else n_pass++;
        n_checks++; if (bus.rx_data !== m_data) $display("FAIL ovr_clr_same_data got=%h exp=%h", bus.rx_data, m_data); else n_pass++;
        pulse_clr();
    endtask

    task automatic test_reset_mid();
        send_frame(DB'(8'h5A), 1'b0, 1'b0, -10, -10, 1'b1);
        model_frame(DB'(8'h5A), 1'b0, 1'b0, 1'b0);
        send_frame(DB'(8'hFF), 1'b1, 1'b0, -10, 5 * C + C / 2, 1'b1);
        model_reset();
        n_checks++; if (snap_rdy !== 1'b0) $display("FAIL rstmid_rdy got=%b exp=0", snap_rdy); else n_pass++;
        n_checks++; if (snap_data !== '0) $display("FAIL rstmid_data got=%h exp=0", snap_data); else n_pass++;
        n_checks++; if ({snap_frm, snap_ovr, snap_par} !== 3'b000) $display("FAIL rstmid_flags got=%b exp=000", {snap_frm, snap_ovr, snap_par}); else n_pass++;
        n_checks++; if (bus.rdy !== 1'b0) $display("FAIL rstmid_no_partial got=%b exp=0", bus.rdy); else n_pass++;
        send_frame(DB'(8'h81), 1'b1, 1'b0, -10, -10, 1'b1);
        model_frame(DB'(8'h81), 1'b1, 1'b0, 1'b0);
        n_checks++; if (rise_edge != LAT) $display("FAIL rstmid_next_latency got=%0d exp=%0d", rise_edge, LAT); else n_pass++;
        n_checks++; if (bus.rx_data !== m_data) $display("FAIL rstmid_next_data got=%h exp=%h", bus.rx_data, m_data); else n_pass++;
        pulse_clr();
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        send_frame(DB'(8'h41), 1'b1, 1'b0, -10, -10, 1'b1);
        model_frame(DB'(8'h41), 1'b1, 1'b0, 1'b0);
        n_checks++; if (bus.par_err !== 1'b0) $display("FAIL par_good got=%b exp=0", bus.par_err); else n_pass++;
        pulse_clr();
        send_frame(DB'(8'h41), 1'b1, 1'b1, -10, -10, 1'b1);
        model_frame(DB'(8'h41), 1'b1, 1'b1, 1'b0);
        n_checks++; if (bus.par_err !== 1'b1) $display("FAIL par_bad got=%b exp=1", bus.par_err); else n_pass++;
        n_checks++; if (bus.rx_data !== m_data) $display("FAIL par_data got=%h exp=%h", bus.rx_data, m_data); else n_pass++;
        pulse_clr();
    endtask
`endif

    task automatic test_random();
        logic [DB-1:0] d;
        bit            stop, pbad, same;
        for (int n = 0; n < 24; n++) begin
            d    = DB'($urandom);
            stop = ($urandom_range(0, 3) != 0);
            pbad = (P == 1) ? bit'($urandom_range(0, 1)) : 1'b0;
            same = ($urandom_range(0, 5) == 0);
            send_frame(d, stop, pbad, same ? LAT : -10, -10, 1'b1);
            model_frame(d, stop, pbad, same);
            n_checks++;
            if ({bus.rdy, bus.frm_err, bus.ovr_err} !== {m_rdy, m_frm, m_ovr} || bus.rx_data !== m_data)
                $display("FAIL rand_%0d got=%b/%b/%b/%h exp=%b/%b/%b/%h", n, bus.rdy, bus.frm_err, bus.ovr_err,
                         bus.rx_data, m_rdy, m_frm, m_ovr, m_data);
            else n_pass++;
`ifdef UART_RX_PARITY_EN
            n_checks++; if (bus.par_err !== m_par) $display("FAIL rand_par_%0d got=%b exp=%b", n, bus.par_err, m_par); else n_pass++;
`endif
            if ($urandom_range(0, 1) == 1) pulse_clr();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_break();
        test_overrun();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
